// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder_scan block: FSM state
// encoding, mode select values and default widths.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DEF_NUM_W   = 2;
    localparam int DEF_DWELL_W = 4;

endpackage : decoder_pkg

// File: rtl/decoder_scan_if.sv
// Control and select bus of decoder_scan. The controller side (master)
// drives enable, mode, index and dwell; the decoder side (slave) returns
// the registered one-hot select and its status.
interface decoder_scan_if #(
    parameter int NUM_W   = decoder_pkg::DEF_NUM_W,
    parameter int DWELL_W = decoder_pkg::DEF_DWELL_W
);

    logic                  en;
    logic                  mode;
    logic                  num_valid;
    logic [NUM_W-1:0]      num;
    logic [DWELL_W-1:0]    dwell;
    logic [2**NUM_W-1:0]   decoder_out;
    logic                  out_valid;
    logic [NUM_W-1:0]      cur_idx;
    logic                  wrap;

    modport master (
        output en, mode, num_valid, num, dwell,
        input  decoder_out, out_valid, cur_idx, wrap
    );

    modport slave (
        input  en, mode, num_valid, num, dwell,
        output decoder_out, out_valid, cur_idx, wrap
    );

endinterface : decoder_scan_if

// File: rtl/dwell_counter.sv
// Dwell-time counter for scan mode. Latches the dwell value on clear and
// on every advance, counts while running, and pulses adv_o in the cycle
// the count reaches the latched value, so each line is held dwell+1 cycles.
// Only instantiated when DECODER_SCAN_EN is defined.
module dwell_counter
    import decoder_pkg::*;
#(
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               run_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               adv_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] limit_q, limit_d;

    assign adv_o = run_i && (cnt_q == limit_q);

    // Next count: restart and resample dwell on clear or advance, else count up.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d   = cnt_q;
        limit_d = limit_q;
        if (clr_i || adv_o) begin
            cnt_d   = '0;
            limit_d = dwell_i;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and latched dwell registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q   <= '0;
            limit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

endmodule : dwell_counter

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with direct and scan modes.
// Direct mode decodes each qualified index; scan mode walks every output
// line, holding each for dwell+1 cycles, and pulses wrap on return to 0.
// Scan mode is built only when DECODER_SCAN_EN is defined; otherwise mode
// is ignored, wrap stays 0 and the block is direct-only.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int NUM_W   = DEF_NUM_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_scan_if.slave  bus
);

    localparam int OUT_W = 2**NUM_W;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic [NUM_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic               mode_eff;

    function automatic logic [OUT_W-1:0] decode(input logic [NUM_W-1:0] i);
        decode    = '0;
        decode[i] = 1'b1;
    endfunction

`ifdef DECODER_SCAN_EN
    logic scan_entry;
    logic scan_stay;
    logic scan_adv;

    assign mode_eff   = bus.mode;
    // Entry and stay are derived from inputs and the current state only,
    // keeping the advance pulse free of any loop through state_d.
    assign scan_entry = bus.en && (bus.mode == MODE_SCAN) && (state_q != SCAN);
    assign scan_stay  = bus.en && (bus.mode == MODE_SCAN) && (state_q == SCAN);

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (scan_entry),
        .run_i   (scan_stay),
        .dwell_i (bus.dwell),
        .adv_o   (scan_adv)
    );
`else
    logic unused_scan_inputs;

    assign mode_eff           = MODE_DIRECT;
    assign unused_scan_inputs = ^{bus.mode, bus.dwell};
`endif

    // Next state and next registered outputs; en overrides mode and num_valid.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
        end else if (mode_eff == MODE_SCAN) begin
            state_d = SCAN;
        end else begin
            state_d = DIRECT;
        end

        case (state_d)
            DIRECT: begin
                // Entering direct shows nothing until the first qualified index.
                if (state_q != DIRECT) begin
                    out_d   = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                end else if (bus.num_valid) begin
                    out_d   = decode(bus.num);
                    valid_d = 1'b1;
                    idx_d   = bus.num;
                end
            end
`ifdef DECODER_SCAN_EN
            SCAN: begin
                if (state_q != SCAN) begin
                    out_d   = decode('0);
                    valid_d = 1'b1;
                    idx_d   = '0;
                end else if (scan_adv) begin
                    out_d   = decode(idx_q + 1'b1);
                    idx_d   = idx_q + 1'b1;
                    wrap_d  = (idx_q == '1);
                end
            end
`endif
            default: begin
                out_d   = '0;
                valid_d = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.decoder_out = out_q;
    assign bus.out_valid   = valid_q;
    assign bus.cur_idx     = idx_q;
    assign bus.wrap        = wrap_q;

endmodule : decoder_scan
